// File: rtl/quad_encoder_counter.sv
// x4 quadrature decoder with synchronizers, a wrapping 0..PPR pulse counter, index handling
// and a sticky illegal-transition flag. All outputs are registered.
module quad_encoder_counter #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter bit          ZERO_ON_INDEX = 1'b1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       A,
  input  logic       B,
  input  logic       Z,
  input  logic [9:0] PPR,
  input  logic       ERR_CLR,
  output logic [9:0] P,
  output logic       DIR,
  output logic       STEP,
  output logic       IDX_SEEN,
  output logic       ERR
);

  typedef enum logic {StPrime, StRun} state_e;

  state_e                 state_q;
  logic [2:0]             prime_cnt_q;
  logic [SYNC_STAGES-1:0] a_sync_q, b_sync_q, z_sync_q;
  logic [1:0]             prev_ab_q;
  logic                   prev_z_q;

  logic [1:0] cur_ab;
  logic       cur_z;
  logic       fwd, rev, illegal, idx_edge, idx_zero;
  logic [9:0] p_inc, p_dec;

  assign cur_ab   = {a_sync_q[SYNC_STAGES-1], b_sync_q[SYNC_STAGES-1]};
  assign cur_z    = z_sync_q[SYNC_STAGES-1];
  assign idx_edge = ~prev_z_q & cur_z;
  assign idx_zero = idx_edge & ZERO_ON_INDEX;
  assign p_inc    = (P == PPR) ? 10'd0 : P + 10'd1;
  assign p_dec    = (P == 10'd0) ? PPR : P - 10'd1;

  // Gray sequence 00->01->11->10 is forward; a two-bit change has no direction.
  always_comb begin
    fwd     = 1'b0;
    rev     = 1'b0;
    illegal = 1'b0;
    unique case ({prev_ab_q, cur_ab})
      4'b0001, 4'b0111, 4'b1110, 4'b1000: fwd     = 1'b1;
      4'b0010, 4'b1011, 4'b1101, 4'b0100: rev     = 1'b1;
      4'b0011, 4'b1100, 4'b0110, 4'b1001: illegal = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StPrime;
      prime_cnt_q <= 3'd0;
      a_sync_q    <= '0;
      b_sync_q    <= '0;
      z_sync_q    <= '0;
      prev_ab_q   <= 2'b00;
      prev_z_q    <= 1'b0;
      P           <= 10'd0;
      DIR         <= 1'b0;
      STEP        <= 1'b0;
      IDX_SEEN    <= 1'b0;
      ERR         <= 1'b0;
    end else begin
      a_sync_q <= {a_sync_q[SYNC_STAGES-2:0], A};
      b_sync_q <= {b_sync_q[SYNC_STAGES-2:0], B};
      z_sync_q <= {z_sync_q[SYNC_STAGES-2:0], Z};
      STEP     <= 1'b0;

      if ((state_q == StRun) && illegal) begin
        ERR <= 1'b1;
      end else if (ERR_CLR) begin
        ERR <= 1'b0;
      end

      unique case (state_q)
        StPrime: begin
          prime_cnt_q <= prime_cnt_q + 3'd1;
          // Chains are full of live input values by the last priming cycle.
          if (prime_cnt_q == 3'(SYNC_STAGES)) begin
            prev_ab_q <= cur_ab;
            prev_z_q  <= cur_z;
            state_q   <= StRun;
          end
        end
        StRun: begin
          prev_ab_q <= cur_ab;
          prev_z_q  <= cur_z;
          if (fwd) DIR <= 1'b1;
          if (rev) DIR <= 1'b0;
          if (idx_edge) IDX_SEEN <= 1'b1;
          if (idx_zero) begin
            P    <= 10'd0;
            STEP <= 1'b1;
          end else if (fwd) begin
            P    <= p_inc;
            STEP <= 1'b1;
          end else if (rev) begin
            P    <= p_dec;
            STEP <= 1'b1;
          end else if (P > PPR) begin
            P <= 10'd0;
          end
        end
        default: state_q <= StPrime;
      endcase
    end
  end

endmodule

// File: tb/tb_quad_encoder_counter.sv
// Bench for quad_encoder_counter: directed vector table, hand-written corner sequences and a
// randomized phase checked every cycle against a delay-line/position-arithmetic model.
module tb_quad_encoder_counter;

  localparam int S = 2;

  logic       CLK = 1'b0;
  logic       RST, A, B, Z, ERR_CLR;
  logic [9:0] PPR;
  logic [9:0] p1, p0;
  logic       dir1, step1, idx1, err1, dir0, step0, idx0, err0;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  quad_encoder_counter #(.SYNC_STAGES(S), .ZERO_ON_INDEX(1'b1)) dut1 (
    .CLK(CLK), .RST(RST), .A(A), .B(B), .Z(Z), .PPR(PPR), .ERR_CLR(ERR_CLR),
    .P(p1), .DIR(dir1), .STEP(step1), .IDX_SEEN(idx1), .ERR(err1)
  );

  quad_encoder_counter #(.SYNC_STAGES(S), .ZERO_ON_INDEX(1'b0)) dut0 (
    .CLK(CLK), .RST(RST), .A(A), .B(B), .Z(Z), .PPR(PPR), .ERR_CLR(ERR_CLR),
    .P(p0), .DIR(dir0), .STEP(step0), .IDX_SEEN(idx0), .ERR(err0)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: pins are seen S+1 edges late; direction comes from gray position delta.
  function automatic int gray_pos(input bit [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  bit [2:0] hist[$];
  int       mp[2];
  bit       mdir[2], mstep[2], midx[2], merr[2];
  bit       mdl_en = 1'b0;

  function automatic void model_step(input int m, input bit run);
    int d, np;
    bit moved, idx;
    moved = 1'b0;
    np    = mp[m];
    d     = run ? (gray_pos(hist[1][2:1]) - gray_pos(hist[0][2:1]) + 4) % 4 : 0;
    idx   = run && !hist[0][0] && hist[1][0];
    if (d == 2) merr[m] = 1'b1;
    else if (ERR_CLR) merr[m] = 1'b0;
    if (d == 1) begin
      np = (mp[m] == int'(PPR)) ? 0 : mp[m] + 1;
      mdir[m] = 1'b1;
      moved = 1'b1;
    end
    if (d == 3) begin
      np = (mp[m] == 0) ? int'(PPR) : mp[m] - 1;
      mdir[m] = 1'b0;
      moved = 1'b1;
    end
    if (idx) begin
      midx[m] = 1'b1;
      if (m == 1) begin
        np = 0;
        moved = 1'b1;
      end
    end
    if (run && !moved && mp[m] > int'(PPR)) np = 0;
    mp[m]    = np;
    mstep[m] = moved;
  endfunction

  always @(posedge CLK) begin
    if (RST) begin
      hist.delete();
      for (int m = 0; m < 2; m++) begin
        mp[m] = 0; mdir[m] = 0; mstep[m] = 0; midx[m] = 0; merr[m] = 0;
      end
    end else begin
      hist.push_back({A, B, Z});
      if (hist.size() > S + 2) void'(hist.pop_front());
      for (int m = 0; m < 2; m++) model_step(m, hist.size() == S + 2);
    end
  end

  always @(negedge CLK) begin
    if (mdl_en) begin
      chk("model_zoi1", int'({p1, dir1, step1, idx1, err1}),
          int'({mp[1][9:0], mdir[1], mstep[1], midx[1], merr[1]}));
      chk("model_zoi0", int'({p0, dir0, step0, idx0, err0}),
          int'({mp[0][9:0], mdir[0], mstep[0], midx[0], merr[0]}));
    end
  end

  // Directed helpers
  int       s1, s0;
  bit [3:0] mask1;
  int       pos = 0;

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wait_cnt(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      s1 += int'(step1);
      s0 += int'(step0);
      if (i < 4) mask1[i] = step1;
    end
  endtask

  task automatic set_ab(input bit [1:0] ab, input int hold);
    s1 = 0; s0 = 0; mask1 = 4'b0000;
    {A, B} = ab;
    pos = gray_pos(ab);
    wait_cnt(hold);
  endtask

  function automatic bit [1:0] gray_of(input int p);
    case (p & 3)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  task automatic move(input bit forward, input int n, input int hold);
    for (int i = 0; i < n; i++) set_ab(gray_of(forward ? pos + 1 : pos + 3), hold);
  endtask

  typedef struct {
    bit [1:0] ab;
    int       exp_p;
    bit       exp_dir;
  } vec_t;

  vec_t vecs[10];
  int   total;

  initial begin
    vecs[0] = '{2'b01, 1, 1'b1};   vecs[1] = '{2'b11, 2, 1'b1};
    vecs[2] = '{2'b10, 3, 1'b1};   vecs[3] = '{2'b00, 4, 1'b1};
    vecs[4] = '{2'b10, 3, 1'b0};   vecs[5] = '{2'b11, 2, 1'b0};
    vecs[6] = '{2'b01, 1, 1'b0};   vecs[7] = '{2'b00, 0, 1'b0};
    vecs[8] = '{2'b10, 599, 1'b0}; vecs[9] = '{2'b00, 0, 1'b1};

    A = 1'b1; B = 1'b1; Z = 1'b0; PPR = 10'd599; ERR_CLR = 1'b0; RST = 1'b1;
    cyc(3);
    mdl_en = 1'b1;
    chk("reset_outputs", int'({p1, dir1, step1, idx1, err1}), 0);
    RST = 1'b0;
    s1 = 0; s0 = 0;
    wait_cnt(10);
    chk("prime_no_step", s1, 0);
    chk("prime_p", int'(p1), 0);
    chk("prime_err", int'(err1), 0);

    // Restart from AB=00 and walk the table
    {A, B} = 2'b00; pos = 0;
    RST = 1'b1; cyc(2); RST = 1'b0; cyc(S + 3);
    total = 0;
    for (int i = 0; i < 10; i++) begin
      set_ab(vecs[i].ab, 4);
      total += s1;
      chk($sformatf("vec%0d_step_latency", i), int'(mask1), 4'b0100);
      chk($sformatf("vec%0d_p", i), int'(p1), vecs[i].exp_p);
      chk($sformatf("vec%0d_dir", i), int'(dir1), int'(vecs[i].exp_dir));
      if (i == 3) chk("fwd_four_steps", total, 4);
    end

    // Illegal transition and ERR_CLR priority
    move(1'b1, 10, 3);
    chk("p_at_10", int'(p1), 10);
    set_ab(2'b00, 4);
    chk("illegal_err", int'(err1), 1);
    chk("illegal_p", int'(p1), 10);
    chk("illegal_no_step", s1, 0);
    ERR_CLR = 1'b1; cyc(1); ERR_CLR = 1'b0;
    chk("err_clr_alone", int'(err1), 0);
    set_ab(2'b01, 4);
    {A, B} = 2'b10; pos = 3;
    cyc(2); ERR_CLR = 1'b1; cyc(1); ERR_CLR = 1'b0;
    chk("err_set_wins", int'(err1), 1);
    cyc(2);
    chk("err_sticky_p", int'(p1), 11);

    // Index behaviour
    move(1'b1, 389, 2);
    cyc(4);
    chk("p_at_400", int'(p1), 400);
    s1 = 0; s0 = 0;
    Z = 1'b1; wait_cnt(4); Z = 1'b0; wait_cnt(4);
    chk("idx_zero_p", int'(p1), 0);
    chk("idx_zero_seen", int'(idx1), 1);
    chk("idx_zero_one_step", s1, 1);
    chk("idx_keep_p", int'(p0), 400);
    chk("idx_keep_seen", int'(idx0), 1);
    chk("idx_keep_no_step", s0, 0);
    set_ab(2'b10, 4);
    chk("rev_wrap_p", int'(p1), 599);
    chk("rev_wrap_dir", int'(dir1), 0);
    Z = 1'b1;
    set_ab(2'b00, 4);
    chk("idx_step_p", int'(p1), 0);
    chk("idx_step_dir", int'(dir1), 1);
    chk("idx_step_one_step", s1, 1);
    chk("idx_step_zoi0_p", int'(p0), 400);
    Z = 1'b0; cyc(4);

    // Runtime PPR reduction
    PPR = 10'd99; cyc(1);
    chk("ppr_oor_p", int'(p0), 0);
    chk("ppr_oor_no_step", int'(step0), 0);
    set_ab(2'b10, 4);
    chk("ppr_rev_p", int'(p0), 99);
    chk("ppr_rev_dir", int'(dir0), 0);

    // Reset mid-sequence, then priming must absorb a pin change made at release
    {A, B} = 2'b00; cyc(2);
    RST = 1'b1; cyc(1);
    chk("midreset_zoi1", int'({p1, dir1, step1, idx1, err1}), 0);
    chk("midreset_zoi0", int'({p0, dir0, step0, idx0, err0}), 0);
    cyc(1);
    {A, B} = 2'b01; pos = 1; RST = 1'b0;
    s1 = 0; wait_cnt(8);
    chk("reprime_no_step", s1, 0);
    chk("reprime_p", int'(p1), 0);

    // Randomized phase, checked every cycle by the model
    PPR = 10'($urandom_range(3, 40));
    for (int it = 0; it < 2000; it++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 70) begin
        move($urandom_range(0, 1) == 1, 1, $urandom_range(2, 5));
      end else if (r < 78) begin
        set_ab(gray_of(pos + 2), $urandom_range(2, 4));
      end else if (r < 86) begin
        Z = ~Z; cyc($urandom_range(2, 4));
      end else if (r < 92) begin
        ERR_CLR = 1'b1; cyc(1); ERR_CLR = 1'b0;
      end else if (r < 97) begin
        PPR = 10'($urandom_range(0, 60)); cyc(1);
      end else begin
        RST = 1'b1; cyc($urandom_range(1, 2)); RST = 1'b0;
      end
    end
    cyc(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/quad_encoder_counter.md
Name: quad_encoder_counter

Overview:
- Upstream stage of the encoder-to-position converter.
- Samples raw quadrature encoder lines A/B and index Z, decodes them in x4 mode, and keeps a wrapping pulse count P in 0..PPR.
- P and PPR feed the position converter directly.
- Also reports direction, a step strobe, index status and a sticky illegal-transition error.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on A, B and Z; legal range 2..4.
- ZERO_ON_INDEX, 1, when 1 a Z rising edge forces P to 0; when 0 Z only sets IDX_SEEN.

Ports:
- CLK  input  1  system clock; all logic is on its rising edge.
- RST  input  1  reset; synchronous, active-high.
- A  input  1  encoder channel A, asynchronous.
- B  input  1  encoder channel B, asynchronous.
- Z  input  1  encoder index, asynchronous.
- PPR  input  10  counts per revolution minus 1 (599 means 600 counts); quasi-static.
- ERR_CLR  input  1  one-cycle pulse that clears ERR.
- P  output  10  current count, 0..PPR.
- DIR  output  1  direction of the last valid step; 1 = forward.
- STEP  output  1  one-cycle pulse whenever P is updated by a step or an index event.
- IDX_SEEN  output  1  sticky; set on the first index edge after reset.
- ERR  output  1  sticky; set on an illegal A/B transition.

Behaviour:
- Reset (RST high at a clock edge):
  - P=0, DIR=0, STEP=0, IDX_SEEN=0, ERR=0.
  - Synchronizer chains, prev-AB register and prev-Z register cleared.
  - FSM goes to PRIME.
  - RST has priority over everything, including mid-operation.
- FSM:
  - PRIME: counts SYNC_STAGES+1 cycles so the synchronizer chains fill with real input values. On the last PRIME cycle, load prev-AB and prev-Z from the synchronized values, then go to RUN. No counting, no ERR and no index action occurs in PRIME.
  - RUN: decode every cycle. Leave RUN only via RST.
- Decode, RUN state only. Compare prev AB with current synchronized AB:
  - Forward sequence 00->01->11->10->00: increment, DIR=1.
  - Reverse sequence: decrement, DIR=0.
  - Unchanged AB: no action.
  - Both bits changed (00<->11, 01<->10): ERR=1, P and DIR unchanged, no STEP.
  - prev-AB is updated every RUN cycle, including after an illegal transition.
- Wrap rules:
  - Increment with P==PPR gives P=0.
  - Decrement with P==0 gives P=PPR.
- Index:
  - A rising edge of synchronized Z (prev-Z=0, cur-Z=1) in RUN sets IDX_SEEN=1.
  - If ZERO_ON_INDEX=1, the same edge also sets P=0 and pulses STEP.
  - If a step and an index edge occur in the same cycle, index wins: P=0. DIR still updates from the step.
- Out-of-range count: if P>PPR (PPR lowered at runtime), P=0 on the next clock with no STEP. Index and step actions take precedence in that cycle.
- ERR_CLR clears ERR. If an illegal transition occurs in the same cycle as ERR_CLR, ERR stays 1 (set wins).
- Latency: an A/B/Z pin change appears on P/STEP/DIR/ERR SYNC_STAGES+1 clocks later.
- Throughput: one count per clock maximum. The encoder must hold each AB state for at least 2 CLK periods; faster input is undefined and may flag ERR.
- All outputs are registered. STEP is high for exactly one cycle per update.

Test Plan:
- Reset with A=1,B=1 held, PPR=599: after reset plus PRIME, ERR=0, P=0, STEP never pulses.
- From P=0, drive AB 00->01->11->10->00 (hold each 4 clocks): P=4, DIR=1, exactly 4 STEP pulses, each SYNC_STAGES+1=3 clocks after its pin edge.
- Wrap, PPR=599: from P=599 one forward step gives P=0. From P=0 one reverse step gives P=599 with DIR=0.
- Illegal transition: AB 00->11 at P=10 gives ERR=1, P=10, no STEP. Then ERR_CLR alone clears ERR. ERR_CLR coincident with a new 01->10 transition leaves ERR=1.
- Index: at P=400 pulse Z with ZERO_ON_INDEX=1, giving P=0, IDX_SEEN=1, one STEP. With ZERO_ON_INDEX=0 the same pulse leaves P=400 and sets IDX_SEEN=1. A step coinciding with the Z edge still yields P=0.
- Runtime PPR change: P=400, set PPR from 599 to 99, giving P=0 next clock with no STEP. Then one reverse step gives P=99. Asserting RST mid-sequence returns all outputs to 0 and re-enters PRIME.
